mu_issue_ctrl: RTL and testbench
================================

# mu_issue_ctrl

Sequencer and writeback arbiter for the iterative multiply unit. Accepts one M-extension multiply request at a time from execute and launches it into the multiply unit with a single-cycle start pulse. Tracks the in-flight destination register for RAW stalls, handles pipeline flushes, and holds the result until the shared register-file write port is free. Sits in the execute stage between the decode/issue logic and the multiply unit.

## Interface
Parameters:
- MU_TIMEOUT, 64: max cycles in WAIT/DRAIN before abort; range 2..255

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- req_valid  in  1  multiply request present
- req_ready  out  1  controller can accept a request
- req_rs1_data, req_rs2_data  in  32  operands
- req_high_low_sel  in  1  1 = upper 32 bits of product
- req_is_signed  in  sign_type_t  operand signedness
- req_rd  in  5  destination register
- mu_start  out  1  one-cycle start pulse to multiply unit
- mu_rs1_data, mu_rs2_data  out  32  registered operands
- mu_high_low_sel  out  1  registered select
- mu_is_signed  out  sign_type_t  registered signedness
- mu_done  in  1  multiply unit result valid (single cycle)
- mu_wdata  in  32  multiply unit result
- src_rs1, src_rs2  in  5  source registers of the instruction in decode
- hazard_stall  out  1  RAW hazard on in-flight rd
- flush  in  1  pipeline flush; kill in-flight op
- alu_wen  in  1  ALU owns the write port this cycle
- mu_wb_wen  out  1  multiply writeback enable
- mu_wb_rd  out  5  writeback register
- mu_wb_data  out  32  writeback data
- ctrl_busy  out  1  state != IDLE
- mu_timeout  out  1  sticky watchdog flag

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN, WB_PEND.
- IDLE: req_ready = !flush. On req_valid && req_ready, register operands, select, signedness and rd, then go to ISSUE.
- ISSUE: mu_start = !flush.
  - flush -> IDLE; the multiply unit is never started.
  - Otherwise -> WAIT, timeout counter cleared.
- WAIT: counter increments each cycle.
  - flush and mu_done in the same cycle -> IDLE, result discarded.
  - flush alone -> DRAIN.
  - mu_done with rd == 0 -> IDLE, no writeback.
  - mu_done with rd != 0 -> latch mu_wdata, go to WB_PEND.
- DRAIN: wait for mu_done, discard the result, go to IDLE. The counter keeps running.
- WB_PEND:
  - mu_wb_wen = !alu_wen && !flush. When it asserts, go to IDLE.
  - flush -> IDLE, no write.
  - alu_wen = 1 -> hold; the ALU always has priority.
- Watchdog: counter reaches MU_TIMEOUT-1 in WAIT or DRAIN without mu_done -> set mu_timeout, go to IDLE, no writeback. mu_timeout clears only on reset.
- hazard_stall = (state is ISSUE, WAIT or WB_PEND) && rd != 0 && (src_rs1 == rd || src_rs2 == rd). It is 0 in DRAIN and IDLE.
- mu_done seen in IDLE, ISSUE or WB_PEND is ignored.
- mu_wb_rd and mu_wb_data come from the internal registers and are valid whenever in WB_PEND.

## Timing
- Reset, asynchronous:
  - State goes to IDLE.
  - All registered data, counter and mu_timeout go to 0.
  - Outputs: req_ready=1, mu_start=0, mu_wb_wen=0, hazard_stall=0, ctrl_busy=0, mu_wb_rd=0, mu_wb_data=0, mu_rs*_data=0.
- Reset mid-operation abandons the op with no writeback.
- Acceptance edge = cycle 0. mu_start is high in cycle 1, with operands stable from cycle 1 until the next acceptance.
- Done in cycle N: result latched at the edge ending cycle N. mu_wb_wen is earliest in cycle N+1.
- Minimum accept-to-writeback latency is 3 cycles, given done the cycle after start.
- req_ready is 0 from cycle 1 until the cycle after return to IDLE. There is no back-to-back issue.
- flush is sampled every cycle and takes precedence over req_valid, mu_done (in WAIT) and writeback.
- All outputs except req_ready, mu_start, mu_wb_wen and hazard_stall are registered. Those four are combinational from state plus flush, alu_wen, rd and src.

## Test plan
- Basic op: req rs1=6, rs2=7, rd=5, high_low_sel=0, mu_done 4 cycles after start with wdata=42, alu_wen=0 -> mu_start exactly one pulse in cycle 1; mu_wb_wen=1, rd=5, data=42 in the cycle after done; then req_ready=1.
- Port contention: alu_wen held 1 for 3 cycles after mu_done -> mu_wb_wen stays 0 for 3 cycles, then writes 42 to rd 5 once; hazard_stall=1 with src_rs1=5 throughout.
- Flush cases:
  - flush in ISSUE -> mu_start never asserts.
  - flush in WAIT, then mu_done 2 cycles later -> no writeback; hazard_stall=0 in DRAIN; return to IDLE.
- rd=0: req with rd=0, src_rs2=0 -> hazard_stall=0 throughout; mu_done produces no mu_wb_wen.
- Watchdog: MU_TIMEOUT=8, mu_done never asserted -> mu_timeout=1 after 8 WAIT cycles, state IDLE, flag persists until nRST pulse.
- Reset mid-op: nRST low during WAIT -> all outputs at reset values immediately; a later mu_done is ignored.

Source files
------------

// File: rtl/mu_issue_ctrl.sv
// Issue sequencer and writeback arbiter for the iterative multiply unit.
// One request in flight at a time; the ALU always wins the shared write port.
module mu_issue_ctrl #(
  parameter int unsigned MU_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_rs1_data,
  input  logic [31:0] req_rs2_data,
  input  logic        req_high_low_sel,
  input  logic [1:0]  req_is_signed,
  input  logic [4:0]  req_rd,
  output logic        mu_start,
  output logic [31:0] mu_rs1_data,
  output logic [31:0] mu_rs2_data,
  output logic        mu_high_low_sel,
  output logic [1:0]  mu_is_signed,
  input  logic        mu_done,
  input  logic [31:0] mu_wdata,
  input  logic [4:0]  src_rs1,
  input  logic [4:0]  src_rs2,
  output logic        hazard_stall,
  input  logic        flush,
  input  logic        alu_wen,
  output logic        mu_wb_wen,
  output logic [4:0]  mu_wb_rd,
  output logic [31:0] mu_wb_data,
  output logic        ctrl_busy,
  output logic        mu_timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, WB_PEND} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MU_TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic [4:0]  rd_reg;
  logic [31:0] rs1_reg;
  logic [31:0] rs2_reg;
  logic        hl_reg;
  logic [1:0]  sgn_reg;
  logic [31:0] wdata_reg;
  logic        timeout_reg;
  logic        rd_match;

  assign rd_match     = (rd_reg != 5'd0) && ((src_rs1 == rd_reg) || (src_rs2 == rd_reg));
  assign req_ready    = (state_reg == IDLE) && !flush;
  assign mu_start     = (state_reg == ISSUE) && !flush;
  assign mu_wb_wen    = (state_reg == WB_PEND) && !alu_wen && !flush;
  assign hazard_stall = rd_match &&
                        ((state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == WB_PEND));

  assign ctrl_busy       = (state_reg != IDLE);
  assign mu_timeout      = timeout_reg;
  assign mu_rs1_data     = rs1_reg;
  assign mu_rs2_data     = rs2_reg;
  assign mu_high_low_sel = hl_reg;
  assign mu_is_signed    = sgn_reg;
  assign mu_wb_rd        = rd_reg;
  assign mu_wb_data      = wdata_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      rd_reg      <= 5'd0;
      rs1_reg     <= 32'd0;
      rs2_reg     <= 32'd0;
      hl_reg      <= 1'b0;
      sgn_reg     <= 2'd0;
      wdata_reg   <= 32'd0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && !flush) begin
            rs1_reg   <= req_rs1_data;
            rs2_reg   <= req_rs2_data;
            hl_reg    <= req_high_low_sel;
            sgn_reg   <= req_is_signed;
            rd_reg    <= req_rd;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (flush) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg   <= 8'd0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg + 8'd1;
          if (flush && mu_done) begin
            state_reg <= IDLE;
          end else if (flush) begin
            state_reg <= DRAIN;
          end else if (mu_done) begin
            if (rd_reg == 5'd0) begin
              state_reg <= IDLE;
            end else begin
              wdata_reg <= mu_wdata;
              state_reg <= WB_PEND;
            end
          end else if (cnt_reg >= CNT_LAST) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        DRAIN: begin
          // The counter is not cleared on flush, so a drain shares the WAIT budget.
          cnt_reg <= cnt_reg + 8'd1;
          if (mu_done) begin
            state_reg <= IDLE;
          end else if (cnt_reg >= CNT_LAST) begin
            timeout_reg <= 1'b1;
            state_reg   <= IDLE;
          end
        end
        WB_PEND: begin
          if (flush || !alu_wen) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mu_issue_ctrl.sv
// Directed bench for mu_issue_ctrl; writebacks are checked against a queue
// of expected {rd, data} entries pushed when each request is issued.
module tb_mu_issue_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_rs1_data, req_rs2_data;
  logic        req_high_low_sel;
  logic [1:0]  req_is_signed;
  logic [4:0]  req_rd;
  logic        mu_start;
  logic [31:0] mu_rs1_data, mu_rs2_data;
  logic        mu_high_low_sel;
  logic [1:0]  mu_is_signed;
  logic        mu_done;
  logic [31:0] mu_wdata;
  logic [4:0]  src_rs1, src_rs2;
  logic        hazard_stall;
  logic        flush;
  logic        alu_wen;
  logic        mu_wb_wen;
  logic [4:0]  mu_wb_rd;
  logic [31:0] mu_wb_data;
  logic        ctrl_busy;
  logic        mu_timeout;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  logic [36:0] exp_q[$];

  always #5 CLK = ~CLK;

  mu_issue_ctrl #(.MU_TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
    .req_high_low_sel(req_high_low_sel), .req_is_signed(req_is_signed), .req_rd(req_rd),
    .mu_start(mu_start), .mu_rs1_data(mu_rs1_data), .mu_rs2_data(mu_rs2_data),
    .mu_high_low_sel(mu_high_low_sel), .mu_is_signed(mu_is_signed),
    .mu_done(mu_done), .mu_wdata(mu_wdata),
    .src_rs1(src_rs1), .src_rs2(src_rs2), .hazard_stall(hazard_stall),
    .flush(flush), .alu_wen(alu_wen),
    .mu_wb_wen(mu_wb_wen), .mu_wb_rd(mu_wb_rd), .mu_wb_data(mu_wb_data),
    .ctrl_busy(ctrl_busy), .mu_timeout(mu_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Writeback monitor: every mu_wb_wen must match the head of the queue.
  always @(negedge CLK) begin
    if (nRST) begin
      if (mu_start) start_cnt++;
      if (mu_wb_wen) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(mu_wb_rd), 32'h0bad);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("wb_rd", 32'(mu_wb_rd), 32'(e[36:32]));
          chk("wb_data", mu_wb_data, e[31:0]);
        end
        $display("[TB] t=%0t writeback rd=%0d data=%0h", $time, mu_wb_rd, mu_wb_data);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Drives one request through the acceptance edge; returns in cycle 1.
  task automatic issue(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] sg);
    req_valid = 1'b1; req_rd = rd; req_rs1_data = a; req_rs2_data = b;
    req_high_low_sel = 1'b0; req_is_signed = sg;
    #2 chk("accept_ready", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 1'b0;
    $display("[TB] t=%0t issue rd=%0d rs1=%0h rs2=%0h", $time, rd, a, b);
  endtask

  initial begin
    nRST = 1'b0; req_valid = 1'b0; req_rs1_data = '0; req_rs2_data = '0;
    req_high_low_sel = 1'b0; req_is_signed = 2'd0; req_rd = '0;
    mu_done = 1'b0; mu_wdata = '0; src_rs1 = '0; src_rs2 = '0;
    flush = 1'b0; alu_wen = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mu_start", 32'(mu_start), 32'd0);
    chk("rst_busy", 32'(ctrl_busy), 32'd0);
    chk("rst_wb_data", mu_wb_data, 32'd0);
    chk("rst_timeout", 32'(mu_timeout), 32'd0);
    cyc(); cyc();
    nRST = 1'b1;
    cyc();

    // Basic op: done 4 cycles after start, writeback the following cycle.
    start_cnt = 0;
    exp_q.push_back({5'd5, 32'd6 * 32'd7});
    issue(5'd5, 32'd6, 32'd7, 2'd2);
    #2 chk("basic_start", 32'(mu_start), 32'd1);
    chk("basic_rs1", mu_rs1_data, 32'd6);
    chk("basic_rs2", mu_rs2_data, 32'd7);
    chk("basic_sgn", 32'(mu_is_signed), 32'd2);
    chk("basic_ready_c1", 32'(req_ready), 32'd0);
    chk("basic_busy", 32'(ctrl_busy), 32'd1);
    cyc();
    #2 chk("basic_start_c2", 32'(mu_start), 32'd0);
    cyc(); cyc(); cyc();
    mu_done = 1'b1; mu_wdata = 32'd42;
    #2 chk("basic_no_wb_done_cycle", 32'(mu_wb_wen), 32'd0);
    cyc();
    mu_done = 1'b0; mu_wdata = 32'd0;
    #2 chk("basic_wb_wen", 32'(mu_wb_wen), 32'd1);
    chk("basic_ready_wb", 32'(req_ready), 32'd0);
    cyc();
    #2 chk("basic_ready_after", 32'(req_ready), 32'd1);
    chk("basic_start_pulses", 32'(start_cnt), 32'd1);

    // Port contention with a RAW hazard on rd 5.
    exp_q.push_back({5'd5, 32'd42});
    src_rs1 = 5'd5;
    issue(5'd5, 32'd6, 32'd7, 2'd0);
    #2 chk("cont_hazard_issue", 32'(hazard_stall), 32'd1);
    cyc();
    mu_done = 1'b1; mu_wdata = 32'd42;
    #2 chk("cont_hazard_wait", 32'(hazard_stall), 32'd1);
    cyc();
    mu_done = 1'b0; alu_wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2 chk("cont_wb_blocked", 32'(mu_wb_wen), 32'd0);
      chk("cont_hazard_wbpend", 32'(hazard_stall), 32'd1);
      cyc();
    end
    alu_wen = 1'b0;
    #2 chk("cont_wb_wen", 32'(mu_wb_wen), 32'd1);
    cyc();
    #2 chk("cont_hazard_idle", 32'(hazard_stall), 32'd0);
    src_rs1 = 5'd0;

    // Flush during ISSUE: the unit is never started.
    start_cnt = 0;
    issue(5'd7, 32'd3, 32'd4, 2'd0);
    flush = 1'b1;
    #2 chk("flush_issue_start", 32'(mu_start), 32'd0);
    cyc();
    flush = 1'b0;
    #2 chk("flush_issue_idle", 32'(ctrl_busy), 32'd0);
    chk("flush_issue_ready", 32'(req_ready), 32'd1);
    chk("flush_issue_pulses", 32'(start_cnt), 32'd0);

    // Flush during WAIT, result arrives two cycles later and is dropped.
    src_rs1 = 5'd9;
    issue(5'd9, 32'd5, 32'd5, 2'd0);
    cyc();
    flush = 1'b1;
    #2 chk("flush_wait_hazard", 32'(hazard_stall), 32'd1);
    cyc();
    flush = 1'b0;
    #2 chk("drain_hazard", 32'(hazard_stall), 32'd0);
    chk("drain_busy", 32'(ctrl_busy), 32'd1);
    cyc();
    mu_done = 1'b1; mu_wdata = 32'd25;
    cyc();
    mu_done = 1'b0;
    #2 chk("drain_no_wb", 32'(mu_wb_wen), 32'd0);
    chk("drain_idle", 32'(ctrl_busy), 32'd0);
    src_rs1 = 5'd0;

    // rd == 0: never a hazard, never a writeback.
    issue(5'd0, 32'd2, 32'd3, 2'd0);
    #2 chk("rd0_hazard_issue", 32'(hazard_stall), 32'd0);
    cyc();
    mu_done = 1'b1; mu_wdata = 32'd6;
    #2 chk("rd0_hazard_wait", 32'(hazard_stall), 32'd0);
    cyc();
    mu_done = 1'b0;
    #2 chk("rd0_no_wb", 32'(mu_wb_wen), 32'd0);
    chk("rd0_idle", 32'(ctrl_busy), 32'd0);

    // Watchdog with MU_TIMEOUT = 8: eight WAIT cycles, then abort.
    issue(5'd3, 32'd1, 32'd1, 2'd0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      #2 chk("wd_busy_wait", 32'(ctrl_busy), 32'd1);
      chk("wd_flag_low", 32'(mu_timeout), 32'd0);
      cyc();
    end
    #2 chk("wd_flag_set", 32'(mu_timeout), 32'd1);
    chk("wd_idle", 32'(ctrl_busy), 32'd0);
    cyc(); cyc();
    #2 chk("wd_flag_sticky", 32'(mu_timeout), 32'd1);

    // Reset during WAIT: outputs return to reset values at once.
    src_rs1 = 5'd5;
    issue(5'd5, 32'd8, 32'd9, 2'd1);
    cyc();
    nRST = 1'b0;
    #1;
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    chk("rstmid_hazard", 32'(hazard_stall), 32'd0);
    chk("rstmid_busy", 32'(ctrl_busy), 32'd0);
    chk("rstmid_wb_rd", 32'(mu_wb_rd), 32'd0);
    chk("rstmid_wb_data", mu_wb_data, 32'd0);
    chk("rstmid_rs1", mu_rs1_data, 32'd0);
    chk("rstmid_timeout", 32'(mu_timeout), 32'd0);
    cyc();
    nRST = 1'b1;
    mu_done = 1'b1; mu_wdata = 32'd99;
    cyc();
    mu_done = 1'b0;
    #2 chk("rstmid_late_done_wb", 32'(mu_wb_wen), 32'd0);
    chk("rstmid_late_done_busy", 32'(ctrl_busy), 32'd0);
    cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
